// File: rtl/hazard_stall_controller.sv
// rtl/hazard_stall_controller.sv - pipeline hazard sequencer for the 5-stage MIPS core
//
// Purpose: combinational load-use / taken-branch / jump hazard decode plus a
// registered RUN/MULDIV FSM that freezes the front of the pipe while a
// multi-cycle mul/div instruction occupies EX.
// Optional feature macro: HAZARD_PERF_CNT_EN (adds saturating event counters).
//
// Ports:
//   clk, reset          core clock, synchronous active-high reset
//   ID_reg_rs/rt        source registers of the instruction in ID
//   ID_uses_rt          ID instruction reads rt
//   ID_jump             jump decoded in ID
//   EX_mem_read         load in EX, EX_reg_rt is its destination
//   EX_muldiv           mul/div instruction in EX
//   EX_branch_taken     branch in EX resolved taken
//   pc_write, IF_ID_write, ID_EX_write    pipeline register enables
//   IF_ID_flush, ID_EX_flush, EX_MEM_bubble  NOP insertion controls
//   muldiv_busy         mul/div freeze active this cycle
//   loaduse_stalls, muldiv_stalls, flush_events  (HAZARD_PERF_CNT_EN only)
module hazard_stall_controller #(
  parameter int MULDIV_CYCLES = 4,
  parameter int CNT_W         = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] ID_reg_rs,
  input  logic [4:0] ID_reg_rt,
  input  logic       ID_uses_rt,
  input  logic       ID_jump,
  input  logic       EX_mem_read,
  input  logic [4:0] EX_reg_rt,
  input  logic       EX_muldiv,
  input  logic       EX_branch_taken,
  output logic       pc_write,
  output logic       IF_ID_write,
  output logic       ID_EX_write,
  output logic       IF_ID_flush,
  output logic       ID_EX_flush,
  output logic       EX_MEM_bubble,
  output logic       muldiv_busy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [15:0] loaduse_stalls,
  output logic [15:0] muldiv_stalls,
  output logic [15:0] flush_events
`endif
);

  typedef enum logic {RUN, MULDIV} state_t;

  // The accepting RUN cycle is already one freeze cycle, so MULDIV counts
  // down the remaining MULDIV_CYCLES-2 freezes and then one release cycle.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_CYCLES - 2);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             freeze;
  logic             load_use;

  always_comb begin
    freeze   = ((state == RUN) && EX_muldiv) || ((state == MULDIV) && (cnt != '0));
    // Register 0 is hard-wired zero, so a load "to" it never creates a hazard.
    load_use = EX_mem_read && (EX_reg_rt != 5'd0) &&
               ((EX_reg_rt == ID_reg_rs) || (ID_uses_rt && (EX_reg_rt == ID_reg_rt)));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      RUN: begin
        if (EX_muldiv) begin
          state_nxt = MULDIV;
          cnt_nxt   = CNT_LOAD;
        end
      end
      MULDIV: begin
        // EX_muldiv is not sampled here: EX still holds the current op.
        if (cnt != '0) cnt_nxt = cnt - CNT_W'(1);
        else           state_nxt = RUN;
      end
    endcase
  end

  always_comb begin
    pc_write      = 1'b1;
    IF_ID_write   = 1'b1;
    ID_EX_write   = 1'b1;
    IF_ID_flush   = 1'b0;
    ID_EX_flush   = 1'b0;
    EX_MEM_bubble = 1'b0;
    muldiv_busy   = 1'b0;
    if (reset) begin
      pc_write      = 1'b0;
      IF_ID_write   = 1'b0;
      ID_EX_write   = 1'b0;
      IF_ID_flush   = 1'b1;
      ID_EX_flush   = 1'b1;
      EX_MEM_bubble = 1'b1;
    end else if (freeze) begin
      pc_write      = 1'b0;
      IF_ID_write   = 1'b0;
      ID_EX_write   = 1'b0;
      EX_MEM_bubble = 1'b1;
      muldiv_busy   = 1'b1;
    end else if (EX_branch_taken) begin
      IF_ID_flush   = 1'b1;
      ID_EX_flush   = 1'b1;
    end else if (load_use) begin
      // A jump in ID waits here; it is re-decoded after the bubble.
      pc_write      = 1'b0;
      IF_ID_write   = 1'b0;
      ID_EX_flush   = 1'b1;
    end else if (ID_jump) begin
      IF_ID_flush   = 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic lu_evt, md_evt, fl_evt;

  always_comb begin
    md_evt = !reset && freeze;
    lu_evt = !reset && !freeze && !EX_branch_taken && load_use;
    fl_evt = !reset && !freeze && (EX_branch_taken || (ID_jump && !load_use));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      loaduse_stalls <= '0;
      muldiv_stalls  <= '0;
      flush_events   <= '0;
    end else begin
      if (lu_evt && (loaduse_stalls != 16'hFFFF)) loaduse_stalls <= loaduse_stalls + 16'd1;
      if (md_evt && (muldiv_stalls  != 16'hFFFF)) muldiv_stalls  <= muldiv_stalls  + 16'd1;
      if (fl_evt && (flush_events   != 16'hFFFF)) flush_events   <= flush_events   + 16'd1;
    end
  end
`endif

endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
Central pipeline hazard sequencer for the 5-stage MIPS core. It works alongside the forwarding unit. It generates PC/IF-ID/ID-EX write enables, flushes and MEM bubbles for four cases: load-use hazards, taken branches, jumps, and a multi-cycle mul/div unit that occupies EX for several cycles. Hazard decode is combinational. The mul/div occupancy is tracked by a registered FSM and counter.

Parameters:
MULDIV_CYCLES, 4, total cycles a mul/div instruction occupies EX (legal range 2..2**CNT_W)
CNT_W, 3, width of the occupancy counter

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-high reset
ID_reg_rs  in  5  rs of instruction in ID
ID_reg_rt  in  5  rt of instruction in ID
ID_uses_rt  in  1  ID instruction reads rt as a source
ID_jump  in  1  jump decoded in ID
EX_mem_read  in  1  load in EX
EX_reg_rt  in  5  load destination in EX
EX_muldiv  in  1  mul/div instruction in EX
EX_branch_taken  in  1  branch in EX resolved taken
pc_write  out  1  PC update enable
IF_ID_write  out  1  IF/ID register enable
ID_EX_write  out  1  ID/EX register enable
IF_ID_flush  out  1  clear IF/ID to NOP
ID_EX_flush  out  1  clear ID/EX to NOP (bubble)
EX_MEM_bubble  out  1  load NOP into EX/MEM
muldiv_busy  out  1  mul/div freeze active this cycle

Behaviour:
- Registered state: FSM {RUN, MULDIV} and cnt[CNT_W-1:0]. Everything else is combinational from state and inputs.
- Reset at clk edge with reset=1: state to RUN, cnt to 0.
- While reset=1, outputs are forced: pc_write=0, IF_ID_write=0, ID_EX_write=0, IF_ID_flush=1, ID_EX_flush=1, EX_MEM_bubble=1, muldiv_busy=0.
- Default outputs (no hazard): pc_write=1, IF_ID_write=1, ID_EX_write=1, all flushes and EX_MEM_bubble=0, muldiv_busy=0.
- Mul/div freeze: freeze = (RUN & EX_muldiv) | (MULDIV & cnt!=0).
  - Freeze outputs: pc_write=0, IF_ID_write=0, ID_EX_write=0, EX_MEM_bubble=1, muldiv_busy=1, flushes=0.
  - RUN & EX_muldiv: go to MULDIV, cnt to MULDIV_CYCLES-2.
  - MULDIV & cnt!=0: cnt decrements.
  - MULDIV & cnt==0: no freeze; go to RUN; the instruction advances at this edge.
  - EX_muldiv is ignored while in MULDIV.
  - Total EX occupancy is exactly MULDIV_CYCLES cycles, with MULDIV_CYCLES-1 freeze cycles.
  - If MULDIV_CYCLES=2: enter MULDIV with cnt=0, giving one freeze cycle.
  - Back-to-back mul/div: the second is accepted in the first RUN cycle after return.
- Priority when not frozen: branch > load-use > jump.
  - Taken branch (EX_branch_taken): IF_ID_flush=1, ID_EX_flush=1, pc_write=1. Load-use and jump are ignored.
  - Load-use: EX_mem_read & EX_reg_rt!=0 & (EX_reg_rt==ID_reg_rs | (ID_uses_rt & EX_reg_rt==ID_reg_rt)). Outputs: pc_write=0, IF_ID_write=0, ID_EX_flush=1. This lasts exactly one cycle, because the bubble removes the load match.
  - Jump: IF_ID_flush=1, pc_write=1. If a load-use hazard is also present, the jump is deferred and re-evaluated the next cycle.
- Freeze overrides all other hazards. Branch/load-use inputs are ignored during freeze, since EX holds the mul/div.
- Register 0 never triggers a load-use stall.
- Reset asserted mid-MULDIV aborts the sequence. The first cycle after reset deassertion is RUN with default outputs.

Optional Feature:
HAZARD_PERF_CNT_EN:
- Defined: adds three outputs, loaduse_stalls[15:0], muldiv_stalls[15:0] and flush_events[15:0].
- Each counter increments once per cycle in which its condition drives outputs:
  - loaduse_stalls: load-use stall cycles.
  - muldiv_stalls: freeze cycles.
  - flush_events: branch or jump flushes.
- Counters clear on reset and saturate at 16'hFFFF.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Load-use on rs: EX_mem_read=1, EX_reg_rt=5, ID_reg_rs=5 -> pc_write=0, IF_ID_write=0, ID_EX_flush=1 for one cycle. With EX_reg_rt=0 instead -> default outputs.
- Load-use on rt: ID_uses_rt=0, ID_reg_rt=EX_reg_rt=7 -> no stall. ID_uses_rt=1 -> one-cycle stall.
- Mul/div with MULDIV_CYCLES=4: EX_muldiv held 4 cycles -> muldiv_busy=1 and EX_MEM_bubble=1 in cycles 1-3, defaults in cycle 4; a second EX_muldiv in cycle 5 -> a new 3-cycle freeze.
- Branch + load-use + jump same cycle -> IF_ID_flush=1, ID_EX_flush=1, pc_write=1. Load-use + jump only -> stall outputs, IF_ID_flush=0.
- Reset asserted in freeze cycle 2 -> forced reset outputs. After deassertion with EX_muldiv=0 -> defaults, muldiv_busy=0.
- HAZARD_PERF_CNT_EN: 70000 consecutive load-use cycles -> loaduse_stalls=16'hFFFF; reset -> 0.
